prefetch_fetch_unit: RTL and testbench

//  Parametrised fetch stage with a reservation-based prefetch queue and a variable-latency instruction-memory port.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/prefetch_fetch_unit.sv | 110 +++++++++++
 tb/tb_prefetch_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the prefetching fetch stage.
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_INST_W = 16;
    localparam int FETCH_DEPTH  = 4;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W = ptr_w(FETCH_DEPTH);
    localparam int INC   = FETCH_INST_W / 8;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_INST_W-1:0] inst;
        logic                    filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Reservation FIFO: entries are allocated at issue, filled by in-order responses,
// and released at the decode handshake. Pointers carry one extra wrap bit.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int INST_W = FETCH_INST_W,
    parameter int DEPTH  = FETCH_DEPTH,
    localparam int P_W   = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_alloc,
    input  logic [ADDR_W-1:0] i_alloc_addr,
    input  logic              i_fill,
    input  logic [INST_W-1:0] i_fill_data,
    input  logic              i_read,
    output logic              o_head_filled,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [INST_W-1:0] o_head_inst,
    output logic [P_W-1:0]    o_used,
    output logic [P_W-1:0]    o_pending
);
    localparam int IDX_W = P_W - 1;

    logic [ADDR_W-1:0] r_addr   [DEPTH];
    logic [INST_W-1:0] r_inst   [DEPTH];
    logic              r_filled [DEPTH];
    logic [P_W-1:0]    r_alloc_ptr, r_fill_ptr, r_read_ptr;

    logic [IDX_W-1:0]  w_alloc_idx, w_fill_idx, w_read_idx;

    assign w_alloc_idx = r_alloc_ptr[IDX_W-1:0];
    assign w_fill_idx  = r_fill_ptr[IDX_W-1:0];
    assign w_read_idx  = r_read_ptr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_read_ptr  <= '0;
        end else begin
            if (i_alloc) r_alloc_ptr <= r_alloc_ptr + P_W'(1);
            if (i_fill)  r_fill_ptr  <= r_fill_ptr + P_W'(1);
            if (i_read)  r_read_ptr  <= r_read_ptr + P_W'(1);
        end
    end

    // Alloc/fill/read never target the same slot in one cycle, so order is free.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst || i_flush) begin
                    r_filled[gi] <= 1'b0;
                end else if (i_alloc && w_alloc_idx == IDX_W'(gi)) begin
                    r_filled[gi] <= 1'b0;
                end else if (i_fill && w_fill_idx == IDX_W'(gi)) begin
                    r_filled[gi] <= 1'b1;
                end else if (i_read && w_read_idx == IDX_W'(gi)) begin
                    r_filled[gi] <= 1'b0;
                end
                if (i_alloc && w_alloc_idx == IDX_W'(gi)) r_addr[gi] <= i_alloc_addr;
                if (i_fill && w_fill_idx == IDX_W'(gi))   r_inst[gi] <= i_fill_data;
            end
        end
    endgenerate

    assign o_head_filled = r_filled[w_read_idx];
    assign o_head_addr   = r_addr[w_read_idx];
    assign o_head_inst   = r_inst[w_read_idx];
    assign o_used        = r_alloc_ptr - r_read_ptr;
    assign o_pending     = r_alloc_ptr - r_fill_ptr;

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Prefetching fetch stage: fetch PC, RUN/DRAIN flush FSM and perf counters around fetch_queue.
// Optional counters built when FETCH_PERF_EN is defined; otherwise the perf ports read zero.
module prefetch_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = FETCH_ADDR_W,
    parameter int              INST_W   = FETCH_INST_W,
    parameter int              DEPTH    = FETCH_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_flushes
);
    localparam int              P_W    = ptr_w(DEPTH);
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_W / 8);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [P_W-1:0]    r_drop_cnt;

    logic              w_head_filled, w_issue, w_fill, w_hs;
    logic [P_W-1:0]    w_used, w_pending, w_outstanding, w_drop_next;

    assign imem_req   = ~rst & (r_state == RUN) & (w_used < P_W'(DEPTH)) & ~redirect;
    assign imem_addr  = r_fetch_pc;
    assign w_issue    = imem_req & imem_gnt;
    assign inst_valid = ~rst & w_head_filled & ~redirect;
    assign w_hs       = inst_valid & inst_ready;

    // In DRAIN the queue is empty, so live requests are exactly the ones still to drop.
    assign w_outstanding = w_pending + r_drop_cnt;
    assign w_fill        = imem_rvalid & ~redirect & (r_state == RUN) & (w_pending != '0);
    assign w_drop_next   = (imem_rvalid && w_outstanding != '0) ? w_outstanding - P_W'(1)
                                                                : w_outstanding;

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (redirect),
        .i_alloc       (w_issue),
        .i_alloc_addr  (r_fetch_pc),
        .i_fill        (w_fill),
        .i_fill_data   (imem_rdata),
        .i_read        (w_hs),
        .o_head_filled (w_head_filled),
        .o_head_addr   (inst_pc),
        .o_head_inst   (inst),
        .o_used        (w_used),
        .o_pending     (w_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_drop_cnt <= w_drop_next;
            r_state    <= (w_drop_next != '0) ? DRAIN : RUN;
        end else begin
            if (w_issue) r_fetch_pc <= r_fetch_pc + PC_INC;
            if (r_state == DRAIN && imem_rvalid && r_drop_cnt != '0) begin
                r_drop_cnt <= r_drop_cnt - P_W'(1);
                if (r_drop_cnt == P_W'(1)) r_state <= RUN;
            end
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && w_outstanding == '0));

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_fetched, r_perf_flushes;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= 16'h0000;
            r_perf_flushes <= 16'h0000;
        end else begin
            if (w_hs && r_perf_fetched != 16'hFFFF)     r_perf_fetched <= r_perf_fetched + 16'd1;
            if (redirect && r_perf_flushes != 16'hFFFF) r_perf_flushes <= r_perf_flushes + 16'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushes = r_perf_flushes;
`else
    assign perf_fetched = 16'h0000;
    assign perf_flushes = 16'h0000;
`endif

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Scoreboard bench for prefetch_fetch_unit with a queued in-order instruction-memory model.
module tb_prefetch_fetch_unit;
    import fetch_pkg::*;

`ifdef FETCH_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic [15:0] perf_fetched, perf_flushes;

    always #5 clk = ~clk;

    prefetch_fetch_unit #(
        .ADDR_W   (FETCH_ADDR_W),
        .INST_W   (FETCH_INST_W),
        .DEPTH    (FETCH_DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready),
        .perf_fetched (perf_fetched),
        .perf_flushes (perf_flushes)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;

    int          gnt_budget, ready_budget, tb_drop;
    bit          rsp_en, redir_req;
    logic [15:0] redir_pc_req, next_pc, last_hs_pc;
    int          issues, hs, flushes, cyc, first_valid;
    logic [15:0]  pending[$];
    fetch_entry_t exp_q[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; inst_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("rst_req", imem_req, 1'b0);
        check_val("rst_valid", inst_valid, 1'b0);
        check_val("rst_perf_fetched", perf_fetched, 16'h0000);
        check_val("rst_perf_flushes", perf_flushes, 16'h0000);
        pending.delete(); exp_q.delete();
        tb_drop = 0; next_pc = 16'h0000; issues = 0; hs = 0; flushes = 0;
        cyc = 0; first_valid = -1; gnt_budget = 0; ready_budget = 0;
        rsp_en = 1'b0; redir_req = 1'b0; redir_pc_req = '0;
        rst = 1'b0;
    endtask

    // One clock: drive inputs at negedge, then score what the next posedge will commit.
    task automatic cycle();
        bit           do_rv;
        logic [15:0]  rv_addr;
        fetch_entry_t e;
        @(negedge clk);
        redirect    = redir_req;
        redirect_pc = redir_pc_req;
        do_rv       = rsp_en && (pending.size() > 0);
        rv_addr     = do_rv ? pending.pop_front() : 16'h0000;
        imem_rvalid = do_rv;
        imem_rdata  = do_rv ? mem_word(rv_addr) : 16'h0000;
        imem_gnt    = (gnt_budget > 0);
        inst_ready  = (ready_budget > 0);
        #1;
        if (inst_valid && first_valid < 0) first_valid = cyc;
        if (redirect) begin
            check_val("req_in_redirect", imem_req, 1'b0);
            check_val("valid_in_redirect", inst_valid, 1'b0);
            tb_drop = pending.size();
            exp_q.delete();
            next_pc = redirect_pc;
            flushes++;
            $display("redirect to %04h, dropping %0d", redirect_pc, tb_drop);
        end else begin
            if (tb_drop > 0) check_val("req_in_drain", imem_req, 1'b0);
            if (do_rv && tb_drop > 0) tb_drop--;
            if (imem_req && imem_gnt) begin
                check_val("issue_addr", imem_addr, next_pc);
                pending.push_back(imem_addr);
                e.addr = next_pc; e.inst = mem_word(next_pc); e.filled = 1'b1;
                exp_q.push_back(e);
                next_pc = next_pc + 16'(INC);
                gnt_budget--;
                issues++;
            end
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("hs_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("inst_pc", inst_pc, e.addr);
                    check_val("inst", inst, e.inst);
                end
                $display("handshake pc=%04h inst=%04h", inst_pc, inst);
                last_hs_pc = inst_pc;
                ready_budget--;
                hs++;
            end
        end
        redir_req = 1'b0;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redir_req = 1'b1;
        redir_pc_req = pc;
        cycle();
    endtask

    int base;

    initial begin
        // Streaming: back-to-back delivery, first valid two cycles after release.
        do_reset();
        gnt_budget = 1000; ready_budget = 1000; rsp_en = 1'b1;
        run(10);
        check_val("t1_first_valid_lat", first_valid, 2);
        check_val("t1_handshakes", hs, 8);

        // Stalled decode fills the queue, one read frees exactly one slot.
        do_reset();
        gnt_budget = 1000; rsp_en = 1'b1;
        run(8);
        check_val("t2_issues_full", issues, 4);
        check_val("t2_req_full", imem_req, 1'b0);
        ready_budget = 1;
        run(4);
        check_val("t2_issues_after_read", issues, 5);
        check_val("t2_hs", hs, 1);
        check_val("t2_req_full_again", imem_req, 1'b0);

        // Redirect with three outstanding and no response in that cycle.
        do_reset();
        gnt_budget = 3;
        run(5);
        check_val("t3_issues", issues, 3);
        do_redirect(16'h0040);
        check_val("t3_drop", tb_drop, 3);
        run(2);
        gnt_budget = 1000; rsp_en = 1'b1;
        base = issues;
        run(3);
        check_val("t3_no_issue_in_drain", issues, base);
        ready_budget = 1;
        run(6);
        check_val("t3_hs", hs, 1);
        check_val("t3_first_pc", last_hs_pc, 16'h0040);

        // Redirect coincident with a stale response: only one more drop.
        do_reset();
        gnt_budget = 2;
        run(4);
        rsp_en = 1'b1;
        do_redirect(16'h0100);
        check_val("t4_drop", tb_drop, 1);
        gnt_budget = 1000;
        cycle();
        base = issues;
        cycle();
        check_val("t4_issue_after_drain", issues, base + 1);
        ready_budget = 1;
        run(4);
        check_val("t4_first_pc", last_hs_pc, 16'h0100);

        // Address wrap at the top of memory does not stall fetch.
        do_reset();
        gnt_budget = 1000; ready_budget = 1000; rsp_en = 1'b1;
        do_redirect(16'hFFFC);
        run(10);
        check_val("t5_issues", issues, 10);
        check_val("t5_hs", hs, 8);

        // Performance counters.
        do_reset();
        gnt_budget = 1000; ready_budget = 5; rsp_en = 1'b1;
        run(12);
        do_redirect(16'h0200);
        run(3);
        do_redirect(16'h0200);
        run(6);
        check_val("t6_hs", hs, 5);
        check_val("t6_perf_fetched", perf_fetched, PERF_ON ? 16'(hs) : 16'h0000);
        check_val("t6_perf_flushes", perf_flushes, PERF_ON ? 16'(flushes) : 16'h0000);
        check_val("t6_perf_fetched_abs", perf_fetched, PERF_ON ? 16'd5 : 16'd0);
        check_val("t6_perf_flushes_abs", perf_flushes, PERF_ON ? 16'd2 : 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
